// File: rtl/irrigacao_pkg.sv
// Shared types, mode encodings and default timing for the irrigation sequencer.
package irrigacao_pkg;

  localparam int unsigned TIMER_W  = 8;
  localparam int unsigned CICLOS_W = 8;
  localparam int unsigned MODO_W   = 2;

  localparam int unsigned T_ABERTURA_DEF = 4;
  localparam int unsigned T_MIN_ON_DEF   = 8;
  localparam int unsigned T_PAUSA_DEF    = 6;
  localparam int unsigned T_TROCA_DEF    = 16;

  localparam logic [MODO_W-1:0] MODO_NENHUM = 2'b00;
  localparam logic [MODO_W-1:0] MODO_GOT    = 2'b01;
  localparam logic [MODO_W-1:0] MODO_ASP    = 2'b10;

  typedef enum logic [2:0] {
    REPOUSO   = 3'd0,
    ABERTURA  = 3'd1,
    IRRIGANDO = 3'd2,
    PAUSA     = 3'd3,
    BLOQUEIO  = 3'd4
  } estado_t;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] inc_sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sequenciador_irrigacao_divisor_display.sv
// Free-running display-select toggle; a forced request overrides the output to 1.
module divisor_display
  import irrigacao_pkg::*;
#(
  parameter int unsigned T_TROCA = T_TROCA_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic forca,
  output logic sel
);

  localparam logic [7:0] LIM_TROCA = 8'(T_TROCA - 1);

  logic [7:0] cnt;
  logic       tog;
  logic       ultimo;
  logic       tog_next;

  assign ultimo   = (cnt == LIM_TROCA);
  assign tog_next = ultimo ? ~tog : tog;

  // forca is the next-cycle lockout, so sel lines up with the registered bloqueio
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tog <= 1'b1;
      sel <= 1'b1;
    end else begin
      cnt <= ultimo ? '0 : cnt + 8'd1;
      tog <= tog_next;
      sel <= tog_next | forca;
    end
  end

endmodule

// File: rtl/sequenciador_irrigacao.sv
// Irrigation sequencer: valve pre-open, pump run, cooldown and fault lockout.
module sequenciador_irrigacao
  import irrigacao_pkg::*;
#(
  parameter int unsigned T_ABERTURA = T_ABERTURA_DEF,
  parameter int unsigned T_MIN_ON   = T_MIN_ON_DEF,
  parameter int unsigned T_PAUSA    = T_PAUSA_DEF,
  parameter int unsigned T_TROCA    = T_TROCA_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gotejamento,
  input  logic                aspersao,
  input  logic                alarme,
  input  logic                erro,
  output logic                bomba,
  output logic                valv_got,
  output logic                valv_asp,
  output logic [MODO_W-1:0]   modo,
  output logic                ocupado,
  output logic                bloqueio,
  output logic                sel_display,
  output logic [CICLOS_W-1:0] ciclos
);

  localparam logic [TIMER_W-1:0] LIM_AB = TIMER_W'(T_ABERTURA - 1);
  localparam logic [TIMER_W-1:0] LIM_ON = TIMER_W'(T_MIN_ON - 1);
  localparam logic [TIMER_W-1:0] LIM_PA = TIMER_W'(T_PAUSA - 1);

  estado_t             state, state_next;
  logic [TIMER_W-1:0]  timer;
  logic [MODO_W-1:0]   modo_next;
  logic                falha;
  logic                pedido;
  logic                conta_ciclo;
  logic                bomba_next, valv_got_next, valv_asp_next;
  logic                ocupado_next, bloqueio_next;

  // State, timer, mode and completed-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= REPOUSO;
      timer  <= '0;
      modo   <= MODO_NENHUM;
      ciclos <= '0;
    end else begin
      state  <= state_next;
      timer  <= (state_next != state) ? '0 : inc_sat8(timer);
      modo   <= modo_next;
      if (conta_ciclo) ciclos <= inc_sat8(ciclos);
    end
  end

  // Next state, next mode and the output decode of the next state
  always_comb begin
    state_next    = state;
    modo_next     = modo;
    conta_ciclo   = 1'b0;
    falha         = alarme | erro;
    pedido        = (modo == MODO_ASP) ? aspersao : gotejamento;

    case (state)
      REPOUSO: begin
        if (falha) begin
          state_next = BLOQUEIO;
          modo_next  = MODO_NENHUM;
        end else if (aspersao) begin
          state_next = ABERTURA;
          modo_next  = MODO_ASP;
        end else if (gotejamento) begin
          state_next = ABERTURA;
          modo_next  = MODO_GOT;
        end
      end
      ABERTURA: begin
        if (falha) begin
          state_next = BLOQUEIO;
          modo_next  = MODO_NENHUM;
        end else if (timer == LIM_AB) begin
          state_next = IRRIGANDO;
        end
      end
      IRRIGANDO: begin
        if (falha) begin
          state_next = BLOQUEIO;
          modo_next  = MODO_NENHUM;
        end else if ((timer >= LIM_ON) && !pedido) begin
          state_next  = PAUSA;
          conta_ciclo = 1'b1;
        end
      end
      PAUSA: begin
        if (falha) begin
          state_next = BLOQUEIO;
          modo_next  = MODO_NENHUM;
        end else if (timer == LIM_PA) begin
          state_next = REPOUSO;
          modo_next  = MODO_NENHUM;
        end
      end
      BLOQUEIO: begin
        modo_next = MODO_NENHUM;
        if (!falha) state_next = PAUSA;
      end
      default: begin
        state_next = REPOUSO;
        modo_next  = MODO_NENHUM;
      end
    endcase

    bomba_next    = (state_next == IRRIGANDO);
    valv_got_next = ((state_next == ABERTURA) || (state_next == IRRIGANDO)) &&
                    (modo_next == MODO_GOT);
    valv_asp_next = ((state_next == ABERTURA) || (state_next == IRRIGANDO)) &&
                    (modo_next == MODO_ASP);
    ocupado_next  = (state_next != REPOUSO);
    bloqueio_next = (state_next == BLOQUEIO);
  end

  // Outputs registered from the next-state decode so they track state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bomba    <= 1'b0;
      valv_got <= 1'b0;
      valv_asp <= 1'b0;
      ocupado  <= 1'b0;
      bloqueio <= 1'b0;
    end else begin
      bomba    <= bomba_next;
      valv_got <= valv_got_next;
      valv_asp <= valv_asp_next;
      ocupado  <= ocupado_next;
      bloqueio <= bloqueio_next;
    end
  end

  divisor_display #(
    .T_TROCA (T_TROCA)
  ) u_divisor (
    .clk   (clk),
    .rst   (rst),
    .forca (bloqueio_next),
    .sel   (sel_display)
  );

endmodule

// File: tb/tb_sequenciador_irrigacao.sv
// Directed self-checking bench for sequenciador_irrigacao with default timing.
module tb_sequenciador_irrigacao;

  logic       clk;
  logic       rst;
  logic       gotejamento, aspersao, alarme, erro;
  logic       bomba, valv_got, valv_asp;
  logic [1:0] modo;
  logic       ocupado, bloqueio, sel_display;
  logic [7:0] ciclos;

  int n_assert = 0;
  int n_fail   = 0;
  int nb       = 0;

  sequenciador_irrigacao dut (
    .clk         (clk),
    .rst         (rst),
    .gotejamento (gotejamento),
    .aspersao    (aspersao),
    .alarme      (alarme),
    .erro        (erro),
    .bomba       (bomba),
    .valv_got    (valv_got),
    .valv_asp    (valv_asp),
    .modo        (modo),
    .ocupado     (ocupado),
    .bloqueio    (bloqueio),
    .sel_display (sel_display),
    .ciclos      (ciclos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_act(input string tag, input logic b, input logic vg, input logic va);
    chk({tag, ".bomba"}, 8'(bomba), 8'(b));
    chk({tag, ".valv_got"}, 8'(valv_got), 8'(vg));
    chk({tag, ".valv_asp"}, 8'(valv_asp), 8'(va));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (ocupado && k < 60) begin
      step();
      k++;
    end
    chk({tag, ".idle"}, 8'(ocupado), 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    gotejamento = 1'b0; aspersao = 1'b0; alarme = 1'b0; erro = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_act("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.modo", 8'(modo), 8'd0);
    chk("reset.ocupado", 8'(ocupado), 8'd0);
    chk("reset.bloqueio", 8'(bloqueio), 8'd0);
    chk("reset.sel", 8'(sel_display), 8'd1);
    chk("reset.ciclos", ciclos, 8'd0);
    rst = 1'b0;

    // display select toggles on the 16th edge after reset
    for (int i = 0; i < 15; i++) begin
      step();
      chk("sel.hold", 8'(sel_display), 8'd1);
    end
    step();
    chk("sel.toggle", 8'(sel_display), 8'd0);

    // single drip pulse: 4 open, 8 pump, 6 pause
    gotejamento = 1'b1;
    step();
    gotejamento = 1'b0;
    chk_act("got.ab0", 1'b0, 1'b1, 1'b0);
    chk("got.modo", 8'(modo), 8'd1);
    chk("got.ocupado", 8'(ocupado), 8'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_act("got.ab", 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk_act("got.irr", 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      chk_act("got.pausa", 1'b0, 1'b0, 1'b0);
      chk("got.pausa.ocupado", 8'(ocupado), 8'd1);
      chk("got.pausa.ciclos", ciclos, 8'd1);
    end
    step();
    chk("got.end.ocupado", 8'(ocupado), 8'd0);
    chk("got.end.modo", 8'(modo), 8'd0);
    chk("got.end.ciclos", ciclos, 8'd1);

    // both requests: sprinkler wins, drip valve never opens
    gotejamento = 1'b1; aspersao = 1'b1;
    step();
    gotejamento = 1'b0; aspersao = 1'b0;
    chk("both.modo", 8'(modo), 8'd2);
    chk_act("both.ab0", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_act("both.ab", 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk_act("both.irr", 1'b1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      chk("both.pausa.valv_got", 8'(valv_got), 8'd0);
    end
    step();
    chk("both.end.ocupado", 8'(ocupado), 8'd0);
    chk("both.end.ciclos", ciclos, 8'd2);

    // sprinkler held 20 cycles; a late drip request must not switch mode
    aspersao = 1'b1;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bomba) nb++;
      if (i >= 10) begin
        chk("hold.valv_got", 8'(valv_got), 8'd0);
        chk("hold.modo", 8'(modo), 8'd2);
      end
      if (i == 9) gotejamento = 1'b1;
    end
    aspersao = 1'b0; gotejamento = 1'b0;
    chk("hold.bomba_cycles", 8'(nb), 8'd16);
    step();
    chk("hold.off.bomba", 8'(bomba), 8'd0);
    chk("hold.off.ciclos", ciclos, 8'd3);
    wait_idle("hold");
    chk("hold.end.ciclos", ciclos, 8'd3);

    // alarm in the third pump cycle forces lockout, then full cooldown
    gotejamento = 1'b1;
    step();
    for (int i = 0; i < 6; i++) step();
    chk("alm.irr3.bomba", 8'(bomba), 8'd1);
    alarme = 1'b1; gotejamento = 1'b0;
    step();
    chk_act("alm.lock", 1'b0, 1'b0, 1'b0);
    chk("alm.bloqueio", 8'(bloqueio), 8'd1);
    chk("alm.sel", 8'(sel_display), 8'd1);
    chk("alm.modo", 8'(modo), 8'd0);
    chk("alm.ciclos", ciclos, 8'd3);
    step();
    chk("alm.hold.bloqueio", 8'(bloqueio), 8'd1);
    chk("alm.hold.sel", 8'(sel_display), 8'd1);
    alarme = 1'b0;
    step();
    chk("alm.pausa.bloqueio", 8'(bloqueio), 8'd0);
    chk_act("alm.pausa", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("alm.pausa.ocupado", 8'(ocupado), 8'd1);
    end
    step();
    chk("alm.end.ocupado", 8'(ocupado), 8'd0);
    chk("alm.end.ciclos", ciclos, 8'd3);

    // sensor error while idle locks out directly
    erro = 1'b1;
    step();
    chk("err.bloqueio", 8'(bloqueio), 8'd1);
    chk("err.ocupado", 8'(ocupado), 8'd1);
    chk("err.sel", 8'(sel_display), 8'd1);
    chk_act("err.lock", 1'b0, 1'b0, 1'b0);
    erro = 1'b0;
    step();
    chk("err.pausa.bloqueio", 8'(bloqueio), 8'd0);
    wait_idle("err");
    chk("err.end.ciclos", ciclos, 8'd3);

    // counter saturation
    for (int i = 0; i < 256; i++) begin
      gotejamento = 1'b1;
      step();
      gotejamento = 1'b0;
      wait_idle("sat");
    end
    chk("sat.ciclos", ciclos, 8'd255);

    // asynchronous reset in the middle of irrigation
    gotejamento = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("rst.pre.bomba", 8'(bomba), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk_act("rst.async", 1'b0, 1'b0, 1'b0);
    chk("rst.async.ocupado", 8'(ocupado), 8'd0);
    chk("rst.async.modo", 8'(modo), 8'd0);
    chk("rst.async.ciclos", ciclos, 8'd0);
    chk("rst.async.sel", 8'(sel_display), 8'd1);
    chk("rst.async.bloqueio", 8'(bloqueio), 8'd0);
    gotejamento = 1'b0;
    step();
    rst = 1'b0;
    gotejamento = 1'b1;
    step();
    gotejamento = 1'b0;
    chk_act("rst.first", 1'b0, 1'b1, 1'b0);
    chk("rst.first.modo", 8'(modo), 8'd1);
    wait_idle("rst");
    chk("rst.end.ciclos", ciclos, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
